reg_status_table: RTL and testbench
===================================

// Module: reg_status_table
// PURPOSE
//  Architectural register status table for the ROB-based out-of-order core.
//  Per arch reg x1..x(NUM_REGS-1): busy bit + producer ROB tag. Dispatch renames a dest reg to a new ROB tag.
//  Commit clears busy only when the committing tag is still the latest producer. Flush clears all busy bits.
//  NUM_RD combinational source-lookup ports feed dispatch; busy_cnt tracks the number of renamed regs.
// PARAMETERS
//  NUM_REGS  32  arch regs incl. x0; x0 has no storage (always ready, tag 0)
//  TAG_W     6   ROB tag width
//  NUM_RD    2   source lookup ports
//  AW        localparam = $clog2(NUM_REGS)
//  CW        localparam = $clog2(NUM_REGS)
// PORTS
//  clk        in   1             clock, all state on posedge
//  reset_n    in   1             asynchronous active-low reset
//  dec_valid  in   1             dispatch rename request
//  dec_rd     in   AW            dispatch dest reg
//  dec_tag    in   TAG_W         ROB tag allocated to dec_rd
//  cmt_valid  in   1             ROB commit
//  cmt_rd     in   AW            committing dest reg
//  cmt_tag    in   TAG_W         committing ROB tag
//  flush      in   1             pipeline flush / mispredict recovery
//  rd_addr    in   NUM_RD*AW     lookup addrs; port i = [i*AW +: AW]
//  rd_ready   out  NUM_RD        1 = value in arch reg is current (not busy)
//  rd_tag     out  NUM_RD*TAG_W  producer tag; port i = [i*TAG_W +: TAG_W]
//  busy_cnt   out  CW            count of regs with busy=1
// BEHAVIOUR
//  - Reset (async, reset_n=0): all busy=0, all tags=0, busy_cnt=0.
//    Outputs then read rd_ready all-1 and rd_tag all-0.
//  - Lookup: combinational from current state.
//    rd_ready[i] = ~busy[rd_addr_i]; rd_tag_i = tag[rd_addr_i].
//    rd_addr_i==0 -> rd_ready=1, rd_tag=0.
//  - Dispatch (dec_valid & dec_rd!=0): next cycle busy[dec_rd]=1, tag[dec_rd]=dec_tag.
//    Renaming an already-busy reg overwrites its tag. dec_rd==0 is ignored.
//  - Commit (cmt_valid & cmt_rd!=0 & busy[cmt_rd] & tag[cmt_rd]==cmt_tag): next cycle busy[cmt_rd]=0.
//    Tag mismatch (reg renamed again since) is a no-op. Commit to a non-busy reg is a no-op.
//  - Same cycle, same reg, dispatch + matching commit: dispatch wins. Reg stays busy with dec_tag.
//  - Same cycle, different regs: both take effect.
//  - Flush: next cycle all busy=0 and busy_cnt=0. Tags keep their values.
//    Flush has priority over dispatch and commit issued in the same cycle; both are dropped.
//  - busy_cnt next value:
//    +1 when dispatch sets a reg that was not busy.
//    -1 when a commit clears a reg.
//    Rename of a busy reg leaves it unchanged. Same-cycle +1/-1 nets to 0.
//    Cannot exceed NUM_REGS-1, so no saturation logic.
//  - Lookup sees pre-update state: a reg dispatched in cycle N reads busy from cycle N+1.
//  - Asserting reset_n low mid-operation returns all state to reset values immediately.
// CONFIGURATION
//  RST_BYPASS_EN defined: a lookup matching a same-cycle valid commit (rd_addr_i==cmt_rd, tag match, no flush) returns rd_ready=1.
//    A same-cycle dispatch to the same reg does NOT suppress this bypass; the lookup still sees pre-dispatch state.
//  RST_BYPASS_EN undefined: no bypass. Such a lookup returns ready=0 and reads ready=1 one cycle later.
//  State update is identical with and without the macro.
// TESTING
//  1 Reset -> all 32 lookups ready=1, tag=0, busy_cnt=0. Dispatch x0 tag 5 -> x0 still ready, busy_cnt=0.
//  2 Dispatch x3 tag 7 -> next cycle rd_ready=0, rd_tag=7, busy_cnt=1.
//    Then commit x3 tag 7 -> ready=1, busy_cnt=0.
//  3 Dispatch x4 tag 1, then x4 tag 9. Commit x4 tag 1 -> x4 still busy, tag 9, busy_cnt=1.
//    Then commit x4 tag 9 -> ready, busy_cnt=0.
//  4 x6 busy tag 2; same cycle commit x6 tag 2 + dispatch x6 tag 12 -> x6 busy, tag 12, busy_cnt unchanged.
//  5 Dispatch x1,x2,x3 -> busy_cnt=3. Flush with dispatch x5 same cycle -> all ready, busy_cnt=0, x5 not busy.
//  6 x8 busy tag 3; lookup x8 during commit x8 tag 3 -> ready=1 with RST_BYPASS_EN, ready=0 without.
//    Both builds read ready=1 next cycle.

Source files
------------

// File: rtl/reg_status_table.sv
// Architectural register status table: per-register busy bit and producer ROB tag,
// with rename on dispatch, tag-checked clear on commit, and global flush.
// Optional macro RST_BYPASS_EN lets a lookup see a same-cycle matching commit as ready.
module reg_status_table #(
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 6,
  parameter int NUM_RD   = 2,
  localparam int AW      = $clog2(NUM_REGS),
  localparam int CW      = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    dec_valid,
  input  logic [AW-1:0]           dec_rd,
  input  logic [TAG_W-1:0]        dec_tag,
  input  logic                    cmt_valid,
  input  logic [AW-1:0]           cmt_rd,
  input  logic [TAG_W-1:0]        cmt_tag,
  input  logic                    flush,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD-1:0]       rd_ready,
  output logic [NUM_RD*TAG_W-1:0] rd_tag,
  output logic [CW-1:0]           busy_cnt
);

  // x0 has no storage; index 0 of the views below is hard-wired to "not busy, tag 0".
  logic [NUM_REGS-1:1] busy_q, busy_d;
  logic [TAG_W-1:0]    tag_q [1:NUM_REGS-1];
  logic [TAG_W-1:0]    tag_d [1:NUM_REGS-1];
  logic [CW-1:0]       busyCnt_q, busyCnt_d;

  logic [NUM_REGS-1:0] busyView;
  logic [TAG_W-1:0]    tagView [0:NUM_REGS-1];

  logic decActive;
  logic cmtMatch;
  logic cmtClear;
  logic cntInc;
  logic cntDec;

  always_comb begin
    busyView   = {busy_q, 1'b0};
    tagView[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      tagView[r] = tag_q[r];
    end
  end

  always_comb begin
    decActive = dec_valid && (dec_rd != '0);
    cmtMatch  = cmt_valid && (cmt_rd != '0) && busyView[cmt_rd] &&
                (tagView[cmt_rd] == cmt_tag);
    // A same-register dispatch keeps the reg busy, so the commit neither clears nor decrements.
    cmtClear  = cmtMatch && !(decActive && (dec_rd == cmt_rd));
    cntInc    = decActive && !busyView[dec_rd];
    cntDec    = cmtClear;
  end

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NUM_REGS; r++) begin
      tag_d[r] = tag_q[r];
    end
    busyCnt_d = busyCnt_q;
    if (flush) begin
      busy_d    = '0;
      busyCnt_d = '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (decActive && (dec_rd == AW'(r))) begin
          busy_d[r] = 1'b1;
          tag_d[r]  = dec_tag;
        end else if (cmtClear && (cmt_rd == AW'(r))) begin
          busy_d[r] = 1'b0;
        end
      end
      busyCnt_d = busyCnt_q + CW'(cntInc) - CW'(cntDec);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q    <= '0;
      busyCnt_q <= '0;
      for (int r = 1; r < NUM_REGS; r++) begin
        tag_q[r] <= '0;
      end
    end else begin
      busy_q    <= busy_d;
      busyCnt_q <= busyCnt_d;
      for (int r = 1; r < NUM_REGS; r++) begin
        tag_q[r] <= tag_d[r];
      end
    end
  end

  always_comb begin
    logic [AW-1:0] addr;
    rd_ready = '0;
    rd_tag   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      addr                      = rd_addr[i*AW +: AW];
      rd_ready[i]               = !busyView[addr];
      rd_tag[i*TAG_W +: TAG_W]  = tagView[addr];
`ifdef RST_BYPASS_EN
      if (cmtMatch && !flush && (addr == cmt_rd)) begin
        rd_ready[i] = 1'b1;
      end
`endif
    end
  end

  assign busy_cnt = busyCnt_q;

endmodule

// File: tb/tb_reg_status_table.sv
// Directed self-checking bench for reg_status_table with hand-computed expectations.
module tb_reg_status_table;

  localparam int NUM_REGS = 32;
  localparam int TAG_W    = 6;
  localparam int NUM_RD   = 2;
  localparam int AW       = 5;
  localparam int CW       = 5;

  logic                    clk;
  logic                    reset_n;
  logic                    dec_valid;
  logic [AW-1:0]           dec_rd;
  logic [TAG_W-1:0]        dec_tag;
  logic                    cmt_valid;
  logic [AW-1:0]           cmt_rd;
  logic [TAG_W-1:0]        cmt_tag;
  logic                    flush;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD-1:0]       rd_ready;
  logic [NUM_RD*TAG_W-1:0] rd_tag;
  logic [CW-1:0]           busy_cnt;

  int checks;
  int passes;
  int fails;

  reg_status_table #(.NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .NUM_RD(NUM_RD)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .dec_valid(dec_valid),
    .dec_rd   (dec_rd),
    .dec_tag  (dec_tag),
    .cmt_valid(cmt_valid),
    .cmt_rd   (cmt_rd),
    .cmt_tag  (cmt_tag),
    .flush    (flush),
    .rd_addr  (rd_addr),
    .rd_ready (rd_ready),
    .rd_tag   (rd_tag),
    .busy_cnt (busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic dv, input int drd, input int dtag,
                               input logic cv, input int crd, input int ctag,
                               input logic fl);
    dec_valid = dv;
    dec_rd    = AW'(drd);
    dec_tag   = TAG_W'(dtag);
    cmt_valid = cv;
    cmt_rd    = AW'(crd);
    cmt_tag   = TAG_W'(ctag);
    flush     = fl;
    #1;
  endtask

  task automatic lookup(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
    #1;
  endtask

  // Advance one clock and return the request inputs to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    dec_valid = 1'b0;
    cmt_valid = 1'b0;
    flush     = 1'b0;
    #1;
  endtask

  initial begin
    checks    = 0;
    passes    = 0;
    fails     = 0;
    reset_n   = 1'b0;
    dec_valid = 1'b0;
    dec_rd    = '0;
    dec_tag   = '0;
    cmt_valid = 1'b0;
    cmt_rd    = '0;
    cmt_tag   = '0;
    flush     = 1'b0;
    rd_addr   = '0;
    #12;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state: every register ready with tag 0.
    for (int i = 0; i < NUM_REGS; i++) begin
      lookup(i, NUM_REGS - 1 - i);
      checkOutput("rst_ready", 32'(rd_ready), 32'h3);
      checkOutput("rst_tag", 32'(rd_tag), 32'h0);
    end
    checkOutput("rst_cnt", 32'(busy_cnt), 32'd0);

    // Dispatch to x0 is ignored.
    applyStimulus(1, 0, 5, 0, 0, 0, 0);
    tick();
    lookup(0, 0);
    checkOutput("x0_ready", 32'(rd_ready), 32'h3);
    checkOutput("x0_tag", 32'(rd_tag), 32'h0);
    checkOutput("x0_cnt", 32'(busy_cnt), 32'd0);

    // Dispatch x3 tag 7, then commit it.
    applyStimulus(1, 3, 7, 0, 0, 0, 0);
    lookup(3, 0);
    checkOutput("x3_pre_ready", 32'(rd_ready), 32'h3);
    tick();
    lookup(3, 0);
    checkOutput("x3_busy_ready", 32'(rd_ready), 32'h2);
    checkOutput("x3_busy_tag", 32'(rd_tag), 32'd7);
    checkOutput("x3_busy_cnt", 32'(busy_cnt), 32'd1);
    applyStimulus(0, 0, 0, 1, 3, 7, 0);
    tick();
    lookup(3, 0);
    checkOutput("x3_cmt_ready", 32'(rd_ready), 32'h3);
    checkOutput("x3_cmt_cnt", 32'(busy_cnt), 32'd0);

    // Stale commit after rename is a no-op.
    applyStimulus(1, 4, 1, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 4, 9, 0, 0, 0, 0);
    tick();
    checkOutput("x4_rename_cnt", 32'(busy_cnt), 32'd1);
    applyStimulus(0, 0, 0, 1, 4, 1, 0);
    tick();
    lookup(0, 4);
    checkOutput("x4_stale_ready", 32'(rd_ready), 32'h1);
    checkOutput("x4_stale_tag", 32'(rd_tag), {20'd0, 6'd9, 6'd0});
    checkOutput("x4_stale_cnt", 32'(busy_cnt), 32'd1);
    applyStimulus(0, 0, 0, 1, 4, 9, 0);
    tick();
    lookup(0, 4);
    checkOutput("x4_cmt_ready", 32'(rd_ready), 32'h3);
    checkOutput("x4_cmt_cnt", 32'(busy_cnt), 32'd0);

    // Same-cycle dispatch and matching commit to x6: dispatch wins.
    applyStimulus(1, 6, 2, 0, 0, 0, 0);
    tick();
    checkOutput("x6_cnt1", 32'(busy_cnt), 32'd1);
    applyStimulus(1, 6, 12, 1, 6, 2, 0);
    tick();
    lookup(6, 0);
    checkOutput("x6_both_ready", 32'(rd_ready), 32'h2);
    checkOutput("x6_both_tag", 32'(rd_tag), 32'd12);
    checkOutput("x6_both_cnt", 32'(busy_cnt), 32'd1);
    applyStimulus(0, 0, 0, 1, 6, 12, 0);
    tick();
    checkOutput("x6_cmt_cnt", 32'(busy_cnt), 32'd0);

    // Flush drops a same-cycle dispatch and keeps tags.
    applyStimulus(1, 1, 11, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 2, 12, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 3, 13, 0, 0, 0, 0);
    tick();
    checkOutput("pre_flush_cnt", 32'(busy_cnt), 32'd3);
    lookup(1, 2);
    checkOutput("pre_flush_ready", 32'(rd_ready), 32'h0);
    applyStimulus(1, 5, 20, 0, 0, 0, 1);
    tick();
    checkOutput("flush_cnt", 32'(busy_cnt), 32'd0);
    lookup(1, 5);
    checkOutput("flush_ready", 32'(rd_ready), 32'h3);
    checkOutput("flush_tag_kept", 32'(rd_tag), {20'd0, 6'd0, 6'd11});
    lookup(2, 3);
    checkOutput("flush_ready23", 32'(rd_ready), 32'h3);

    // Lookup during a matching commit to x8.
    applyStimulus(1, 8, 3, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 8, 3, 0);
    lookup(8, 0);
`ifdef RST_BYPASS_EN
    checkOutput("x8_bypass_ready", 32'(rd_ready), 32'h3);
`else
    checkOutput("x8_bypass_ready", 32'(rd_ready), 32'h2);
`endif
    tick();
    lookup(8, 0);
    checkOutput("x8_cmt_ready", 32'(rd_ready), 32'h3);
    checkOutput("x8_cmt_cnt", 32'(busy_cnt), 32'd0);

    // Dispatch and commit to different regs in one cycle; commit to an idle reg is ignored.
    applyStimulus(1, 10, 4, 0, 0, 0, 0);
    tick();
    applyStimulus(1, 11, 5, 1, 10, 4, 0);
    tick();
    lookup(10, 11);
    checkOutput("diff_ready", 32'(rd_ready), 32'h1);
    checkOutput("diff_tag", 32'(rd_tag), {20'd0, 6'd5, 6'd4});
    checkOutput("diff_cnt", 32'(busy_cnt), 32'd1);
    applyStimulus(0, 0, 0, 1, 12, 0, 0);
    tick();
    checkOutput("idle_cmt_cnt", 32'(busy_cnt), 32'd1);

    // Asynchronous reset mid-operation.
    #2;
    reset_n = 1'b0;
    #1;
    lookup(11, 10);
    checkOutput("async_rst_cnt", 32'(busy_cnt), 32'd0);
    checkOutput("async_rst_ready", 32'(rd_ready), 32'h3);
    checkOutput("async_rst_tag", 32'(rd_tag), 32'h0);
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
